ray_generator: RTL and testbench

//  Primary-ray source for the tracer. It walks an IMG_W x IMG_H pixel grid in raster order and forms one

---
 rtl/rt_pkg.sv | 23 ++
 rtl/ray_generator.sv | 143 ++++++++++++++
 tb/tb_ray_generator.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rt_pkg.sv
// Shared definitions for the ray tracer front end: word widths, ray word
// layout and the ray generator state encoding.
package rt_pkg;

    localparam int Q_BITS = 10;
    localparam int D_BITS = 32;

    // Word positions inside a ray: origin x,y,z then direction x,y,z.
    localparam int RAY_OX = 0;
    localparam int RAY_OY = 1;
    localparam int RAY_OZ = 2;
    localparam int RAY_DX = 3;
    localparam int RAY_DY = 4;
    localparam int RAY_DZ = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ray_generator.sv
// Primary-ray source: walks the pixel grid in raster order and writes one
// pinhole-camera ray per pixel into the ray FIFO, one frame per start pulse.
//
// Handshake: out_wr_en is a registered strobe. A ray is offered in WRITE and
// the strobe is raised only on an edge where out_full was low, so the strobe
// is high for exactly one cycle with ray_out stable during that cycle. The
// FIFO must reflect the write in out_full by the following cycle.
module ray_generator
    import rt_pkg::*;
#(
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int C_BITS    = 12,
    parameter int PIX_SHIFT = 10,
    parameter int FOCAL     = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0][D_BITS-1:0] cam_origin,
    output logic                   busy,
    output logic                   done,
    input  logic                   out_full,
    output logic                   out_wr_en,
    output logic [5:0][D_BITS-1:0] ray_out,
    output logic [C_BITS-1:0]      pixel_col,
    output logic [C_BITS-1:0]      pixel_row,
    output state_t                 dbg_state
);

    state_t                 state_q, state_d;
    logic [C_BITS-1:0]      col_q, col_d;
    logic [C_BITS-1:0]      row_q, row_d;
    logic [2:0][D_BITS-1:0] origin_q, origin_d;
    logic [5:0][D_BITS-1:0] ray_q, ray_d;
    logic                   wr_q, wr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic signed [D_BITS-1:0] off_x;
    logic signed [D_BITS-1:0] off_y;
    logic                     last_col;
    logic                     last_row;

    // Signed pixel offsets from the image centre; +y points up so rows count down.
    always_comb begin
        off_x    = $signed(D_BITS'(col_q)) - $signed(D_BITS'(IMG_W / 2));
        off_y    = $signed(D_BITS'(IMG_H / 2)) - $signed(D_BITS'(row_q));
        last_col = (col_q == C_BITS'(IMG_W - 1));
        last_row = (row_q == C_BITS'(IMG_H - 1));
    end

    // Next-state and output decode; strobe and done default low every cycle.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        origin_d = origin_q;
        ray_d    = ray_q;
        wr_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    origin_d = cam_origin;
                    col_d    = '0;
                    row_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                ray_d[RAY_OX] = origin_q[0];
                ray_d[RAY_OY] = origin_q[1];
                ray_d[RAY_OZ] = origin_q[2];
                ray_d[RAY_DX] = off_x <<< PIX_SHIFT;
                ray_d[RAY_DY] = off_y <<< PIX_SHIFT;
                ray_d[RAY_DZ] = D_BITS'(FOCAL);
                state_d       = WRITE;
            end
            WRITE: begin
                // A full FIFO freezes ray and counters until space appears.
                if (!out_full) begin
                    wr_d = 1'b1;
                    if (last_col) begin
                        if (last_row) begin
                            state_d = DONE;
                        end else begin
                            col_d   = '0;
                            row_d   = row_q + 1'b1;
                            state_d = CALC;
                        end
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = CALC;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            origin_q <= '0;
            ray_q    <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            origin_q <= origin_d;
            ray_q    <= ray_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_wr_en = wr_q;
    assign ray_out   = ray_q;
    assign pixel_col = col_q;
    assign pixel_row = row_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ray_generator.sv
// Directed bench for ray_generator on a 4x2 image.
module tb_ray_generator;
    import rt_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CB = 12;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [2:0][31:0]   cam_origin = '0;
    logic               busy;
    logic               done;
    logic               out_full = 1'b0;
    logic               out_wr_en;
    logic [5:0][31:0]   ray_out;
    logic [CB-1:0]      pixel_col;
    logic [CB-1:0]      pixel_row;
    state_t             dbg_state;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    logic full_at_edge = 1'b0;
    logic [191:0] exp_q[$];
    logic [191:0] cap_q[$];

    ray_generator #(
        .IMG_W(W), .IMG_H(H), .C_BITS(CB), .PIX_SHIFT(10), .FOCAL(4096)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cam_origin(cam_origin),
        .busy(busy), .done(done), .out_full(out_full), .out_wr_en(out_wr_en),
        .ray_out(ray_out), .pixel_col(pixel_col), .pixel_row(pixel_row),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] w(input int v);
        return v;
    endfunction

    function automatic logic [191:0] pack(input int ox, oy, oz, dx, dy, dz);
        return {w(ox), w(oy), w(oz), w(dx), w(dy), w(dz)};
    endfunction

    // Expected rays of a whole frame in raster order.
    task automatic expect_frame(input int ox, oy, oz);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(pack(ox, oy, oz, (c - W / 2) * 1024, (H / 2 - r) * 1024, 4096));
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start(input int ox, oy, oz);
        cam_origin = {w(oz), w(oy), w(ox)};
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (strobe_cnt < n && k < budget) begin
            tick();
            k++;
        end
        if (strobe_cnt < n) check("strobe_timeout", 1, 0);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int k = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && k < budget) begin
            if (rnd) out_full = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        out_full = 1'b0;
        if (done_cnt == d0) check("done_timeout", 1, 0);
    endtask

    task automatic new_frame();
        strobe_cnt = 0;
        done_cnt = 0;
        cap_q.delete();
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clock) full_at_edge <= out_full;

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (out_wr_en) begin
            logic [191:0] got;
            got = {ray_out[0], ray_out[1], ray_out[2], ray_out[3], ray_out[4], ray_out[5]};
            strobe_cnt++;
            cap_q.push_back(got);
            check("strobe_while_full", {191'd0, full_at_edge}, 192'd0);
            if (exp_q.size() == 0) check("unexpected_ray", got, 192'd0);
            else check("ray", got, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr", out_wr_en, 0);
        check("rst_ray", ray_out, 0);
        check("rst_col", pixel_col, 0);
        check("rst_row", pixel_row, 0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b0;
        tick();

        // 1: plain frame, latency and first/last ray values
        new_frame();
        expect_frame(0, 0, -8192);
        cam_origin = {w(-8192), w(0), w(0)};
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_wr_lat0", out_wr_en, 0);
        tick();
        check("t1_wr_lat1", out_wr_en, 0);
        tick();
        check("t1_wr_lat2", out_wr_en, 1);
        wait_done(100, 0);
        check("t1_strobes", strobe_cnt, 8);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_after", busy, 0);
        check("t1_sb_empty", exp_q.size(), 0);
        if (cap_q.size() == 8) begin
            check("t1_first", cap_q[0], pack(0, 0, -8192, -2048, 1024, 4096));
            check("t1_last", cap_q[7], pack(0, 0, -8192, 1024, 0, 4096));
        end else check("t1_cap_size", cap_q.size(), 8);
        tick();
        check("t1_done_pulse", done_cnt, 1);

        // 2+3: stall at the 3rd ray, ignored start at the 4th
        new_frame();
        expect_frame(7, -3, 2048);
        pulse_start(7, -3, 2048);
        wait_strobes(2, 50);
        out_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_wr_stall", out_wr_en, 0);
            check("t2_dx_frozen", ray_out[3], w(0));
            check("t2_dy_frozen", ray_out[4], w(1024));
            check("t2_col_frozen", pixel_col, 2);
            check("t2_row_frozen", pixel_row, 0);
        end
        check("t2_strobes_stalled", strobe_cnt, 2);
        out_full = 1'b0;
        wait_strobes(3, 20);
        if (cap_q.size() == 3) check("t2_third", cap_q[2], pack(7, -3, 2048, 0, 1024, 4096));
        else check("t2_cap_size", cap_q.size(), 3);
        pulse_start(5, 5, 5);
        wait_done(100, 0);
        check("t3_strobes", strobe_cnt, 8);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_sb_empty", exp_q.size(), 0);
        tick();

        new_frame();
        expect_frame(5, 5, 5);
        pulse_start(5, 5, 5);
        wait_done(100, 0);
        check("t3b_strobes", strobe_cnt, 8);
        check("t3b_sb_empty", exp_q.size(), 0);
        tick();

        // 4: asynchronous reset during the 5th WRITE
        new_frame();
        expect_frame(0, 0, -8192);
        pulse_start(0, 0, -8192);
        wait_strobes(4, 50);
        tick();
        check("t4_in_write", dbg_state, WRITE);
        reset = 1'b1;
        #1;
        check("t4_wr", out_wr_en, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_ray", ray_out, 0);
        check("t4_col", pixel_col, 0);
        check("t4_row", pixel_row, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t4_strobes", strobe_cnt, 4);
        check("t4_no_done", done_cnt, 0);
        exp_q.delete();

        new_frame();
        expect_frame(0, 0, -8192);
        pulse_start(0, 0, -8192);
        check("t4_restart_col", pixel_col, 0);
        check("t4_restart_row", pixel_row, 0);
        wait_done(100, 0);
        check("t4_restart_strobes", strobe_cnt, 8);
        check("t4_restart_sb", exp_q.size(), 0);
        tick();

        // 5: random back-pressure
        new_frame();
        expect_frame(-100, 300, 12);
        pulse_start(-100, 300, 12);
        wait_done(2000, 1);
        check("t5_strobes", strobe_cnt, 8);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_sb_empty", exp_q.size(), 0);
        check("t5_busy_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
